// File: rtl/bbpd_dco_loop.sv
// bbpd_dco_loop: bang-bang PI loop filter driving a phase-accumulator DCO for the ADPLL
//   clk_i      in   system clock
//   reset_n_i  in   asynchronous active-low reset
//   enable_i   in   loop enable; low parks the loop at FCW_INIT
//   pd_i       in   bang-bang decision (1 = raise freq), asynchronous to clk_i
//   gen_o      out  generated clock (registered accumulator MSB)
//   fcw_o      out  effective frequency control word (integral + one-period proportional kick)
//   update_o   out  one-cycle strobe when a decision is applied
//   lock_o     out  lock flag; lock detector built only when BBPD_LOCK_DETECT_EN is defined
module bbpd_dco_loop #(
   parameter int               ACC_W    = 24,
   parameter logic [ACC_W-1:0] FCW_INIT = 24'h010000,
   parameter logic [ACC_W-1:0] FCW_MIN  = 24'h008000,
   parameter logic [ACC_W-1:0] FCW_MAX  = 24'h020000,
   parameter int               KI       = 16,
   parameter int               KP       = 256,
   parameter int               LOCK_CNT = 32
) (
   input  logic             clk_i,
   input  logic             reset_n_i,
   input  logic             enable_i,
   input  logic             pd_i,
   output logic             gen_o,
   output logic [ACC_W-1:0] fcw_o,
   output logic             update_o,
   output logic             lock_o
);
   localparam int SW = ACC_W + 2;
   localparam logic signed [SW-1:0] KI_S  = SW'(KI);
   localparam logic signed [SW-1:0] KP_S  = SW'(KP);
   localparam logic signed [SW-1:0] MIN_S = $signed({2'b00, FCW_MIN});
   localparam logic signed [SW-1:0] MAX_S = $signed({2'b00, FCW_MAX});

   if (LOCK_CNT < 1) begin : g_bad_lock_cnt
      $error("LOCK_CNT must be positive");
   end

   logic [ACC_W-1:0]     acc, integ;
   logic                 gen_q, pd_meta, pd_s;
   logic [2:0]           strobe;
   logic signed [SW-1:0] nxt_i, nxt_f;

   function automatic logic [ACC_W-1:0] sat(input logic signed [SW-1:0] v);
      return v < MIN_S ? FCW_MIN : v > MAX_S ? FCW_MAX : v[ACC_W-1:0];
   endfunction

   // proportional kick is taken from the unsaturated integral step
   assign nxt_i    = pd_s ? $signed({2'b00, integ}) + KI_S : $signed({2'b00, integ}) - KI_S;
   assign nxt_f    = pd_s ? nxt_i + KP_S : nxt_i - KP_S;
   assign update_o = strobe[2];

   always_ff @(posedge clk_i or negedge reset_n_i)
      if (!reset_n_i) begin
         acc     <= '0;
         gen_o   <= 1'b0;
         gen_q   <= 1'b0;
         pd_meta <= 1'b0;
         pd_s    <= 1'b0;
         strobe  <= '0;
         integ   <= FCW_INIT;
         fcw_o   <= FCW_INIT;
      end else begin
         acc     <= acc + fcw_o;
         gen_o   <= acc[ACC_W-1];
         gen_q   <= gen_o;
         pd_meta <= pd_i;
         pd_s    <= pd_meta;
         // each gen rise travels its own slot, so back-to-back rises are never merged
         strobe  <= {strobe[1:0], gen_o & ~gen_q};
         if (!enable_i) begin
            integ <= FCW_INIT;
            fcw_o <= FCW_INIT;
         end else if (update_o) begin
            integ <= sat(nxt_i);
            fcw_o <= sat(nxt_f);
         end
      end

`ifdef BBPD_LOCK_DETECT_EN
   localparam int CW = $clog2(LOCK_CNT + 1);
   logic [CW-1:0] lock_cnt;
   logic          have_prev, prev_pd;

   always_ff @(posedge clk_i or negedge reset_n_i)
      if (!reset_n_i) begin
         lock_cnt  <= '0;
         have_prev <= 1'b0;
         prev_pd   <= 1'b0;
      end else if (!enable_i) begin
         lock_cnt  <= '0;
         have_prev <= 1'b0;
      end else if (update_o) begin
         have_prev <= 1'b1;
         prev_pd   <= pd_s;
         if (have_prev)
            lock_cnt <= pd_s == prev_pd ? '0 : lock_cnt == CW'(LOCK_CNT) ? lock_cnt : lock_cnt + 1'b1;
      end

   assign lock_o = lock_cnt == CW'(LOCK_CNT);
`else
   assign lock_o = 1'b0;
`endif
endmodule

// File: tb/tb_bbpd_dco_loop.sv
// tb_bbpd_dco_loop: randomized and directed checks of bbpd_dco_loop against a cycle model
module tb_bbpd_dco_loop;
   localparam int MAXC = 100000;
   localparam int FI   = 'h010000;
   localparam int FMIN = 'h008000;
   localparam int FMAX = 'h020000;
   localparam int KP   = 256;
   localparam int LC   = 32;
   localparam int KI0  = 16;
   localparam int KI1  = 4096;

   logic        clk = 1'b0, rst_n = 1'b0, enable_i = 1'b0, pd_i = 1'b0;
   logic        gen0, gen1, upd0, upd1, lock0, lock1;
   logic [23:0] fcw0, fcw1;
   int          checks = 0, failures = 0;

   bbpd_dco_loop u_dut0 (
      .clk_i(clk), .reset_n_i(rst_n), .enable_i(enable_i), .pd_i(pd_i),
      .gen_o(gen0), .fcw_o(fcw0), .update_o(upd0), .lock_o(lock0)
   );

   bbpd_dco_loop #(.KI(KI1)) u_dut1 (
      .clk_i(clk), .reset_n_i(rst_n), .enable_i(enable_i), .pd_i(pd_i),
      .gen_o(gen1), .fcw_o(fcw1), .update_o(upd1), .lock_o(lock1)
   );

   always #5 clk = ~clk;

   // model: k counts clock edges since reset release; histories indexed by edge
   int k;
   int m_acc[2], m_integ[2], m_fcw[2], m_run[2];
   bit m_prev[2];
   bit gen_hist[2][0:MAXC];
   bit pd_hist[0:MAXC];

   function automatic int clamp(int v);
      return v < FMIN ? FMIN : (v > FMAX ? FMAX : v);
   endfunction

   function automatic bit rise(int i, int j);
      return j >= 1 && gen_hist[i][j] && !gen_hist[i][j-1];
   endfunction

   function automatic bit exp_upd(int i, int j);
      return j >= 3 && rise(i, j - 3);
   endfunction

   function automatic bit exp_lock(int i);
`ifdef BBPD_LOCK_DETECT_EN
      return m_run[i] >= LC + 1;
`else
      return m_run[i] < 0;
`endif
   endfunction

   task automatic cmp(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s at edge %0d: got %h, expected %h", name, k, act, exp);
      end
   endtask

   task automatic model_reset();
      k = 0;
      pd_hist[0] = 1'b0;
      for (int i = 0; i < 2; i++) begin
         m_acc[i] = 0; m_integ[i] = FI; m_fcw[i] = FI; m_run[i] = 0; m_prev[i] = 1'b0;
         gen_hist[i][0] = 1'b0;
      end
   endtask

   task automatic model_edge();
      bit ps, u;
      int ki, d;
      k++;
      if (k > MAXC) begin
         $display("FAIL model_capacity edge=%0d limit=%0d", k, MAXC);
         $fatal(1);
      end
      pd_hist[k] = pd_i;
      ps = (k - 1 >= 2) ? pd_hist[k-2] : 1'b0;
      for (int i = 0; i < 2; i++) begin
         u = exp_upd(i, k - 1);
         gen_hist[i][k] = m_acc[i] >= 'h800000;
         m_acc[i] = (m_acc[i] + m_fcw[i]) % 'h1000000;
         if (!enable_i) begin
            m_integ[i] = FI; m_fcw[i] = FI; m_run[i] = 0;
         end else if (u) begin
            ki = i ? KI1 : KI0;
            d = ps ? 1 : -1;
            m_fcw[i] = clamp(m_integ[i] + d * (ki + KP));
            m_integ[i] = clamp(m_integ[i] + d * ki);
            m_run[i] = (m_run[i] > 0 && ps != m_prev[i]) ? m_run[i] + 1 : 1;
            m_prev[i] = ps;
         end
      end
   endtask

   // the single compare point: every cycle, away from the active edge
   task automatic step();
      @(negedge clk);
      if (!rst_n) model_reset(); else model_edge();
      cmp("gen0", gen0, gen_hist[0][k]);
      cmp("fcw0", fcw0, m_fcw[0]);
      cmp("upd0", upd0, exp_upd(0, k));
      cmp("lock0", lock0, exp_lock(0));
      cmp("gen1", gen1, gen_hist[1][k]);
      cmp("fcw1", fcw1, m_fcw[1]);
      cmp("upd1", upd1, exp_upd(1, k));
      cmp("lock1", lock1, exp_lock(1));
   endtask

   task automatic wait_upd(int i, int n);
      int seen = 0, b = 0;
      while (seen < n && b < n * 1200 + 1200) begin
         step();
         b++;
         if (i == 0 ? upd0 : upd1) seen++;
      end
      cmp("update_timeout", seen, n);
      step();
   endtask

   initial begin
      int b, pg, cnt, t0;
      step();
      step();
      cmp("rst_gen", gen0, 0);
      cmp("rst_fcw", fcw0, 'h010000);
      cmp("rst_upd", upd0, 0);
      cmp("rst_lock", lock0, 0);
      rst_n = 1'b1;
      enable_i = 1'b1;
      pd_i = 1'b1;
      pg = gen0; b = 0;
      while (!(gen0 && !pg) && b < 400) begin pg = gen0; step(); b++; end
      cmp("first_rise_seen", int'(gen0 && !pg), 1);
      cnt = 0;
      while (!upd0 && cnt < 10) begin step(); cnt++; end
      cmp("rise_to_update", cnt, 3);
      step();
      cmp("fcw_after_1_up", fcw0, 'h010110);
      wait_upd(0, 3);
      cmp("fcw_after_4_up", fcw0, 'h010140);
      enable_i = 1'b0;
      pd_i = 1'b0;
      step();
      cmp("disable_fcw", fcw0, 'h010000);
      cmp("disable_lock", lock0, 0);
      repeat (10) step();
      enable_i = 1'b1;
      wait_upd(0, 1);
      cmp("reenable_down_1", fcw0, 'h00FEF0);
      wait_upd(0, 1);
      cmp("reenable_down_2", fcw0, 'h00FEE0);
      wait_upd(1, 10);
      cmp("clamp_min", fcw1, 'h008000);
      pd_i = 1'b1;
      wait_upd(1, 30);
      cmp("clamp_max", fcw1, 'h020000);
      pg = gen1; b = 0;
      while (!(gen1 && !pg) && b < 300) begin pg = gen1; step(); b++; end
      t0 = k; pg = gen1; b = 0;
      step();
      while (!(gen1 && !pg) && b < 300) begin pg = gen1; step(); b++; end
      cmp("gen_period_max", k - t0, 128);
      enable_i = 1'b0;
      repeat (5) step();
      enable_i = 1'b1;
      for (int n = 1; n <= 33; n++) begin
         wait_upd(0, 1);
`ifdef BBPD_LOCK_DETECT_EN
         if (n == 32) cmp("lock_at_32", lock0, 0);
         if (n == 33) cmp("lock_at_33", lock0, 1);
`endif
         if (n < 33) pd_i = ~pd_i;
      end
      wait_upd(0, 1);
`ifdef BBPD_LOCK_DETECT_EN
      cmp("lock_drop_repeat", lock0, 0);
`endif
      for (int n = 0; n < 20000; n++) begin
         pd_i = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1999) == 0) enable_i = ~enable_i;
         step();
      end
      enable_i = 1'b1;
      wait_upd(0, 1);
      #2 rst_n = 1'b0;
      #1;
      cmp("async_rst_gen", gen0, 0);
      cmp("async_rst_fcw", fcw0, 'h010000);
      cmp("async_rst_upd", upd0, 0);
      cmp("async_rst_fcw1", fcw1, 'h010000);
      step();
      step();
      rst_n = 1'b1;
      repeat (500) begin
         pd_i = 1'($urandom_range(0, 1));
         step();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/bbpd_dco_loop.md
Name: bbpd_dco_loop

Overview:
- Digital loop filter plus numerically controlled oscillator for the ADPLL.
- Consumes the 1-bit bang-bang phase-detector decision and produces the generated clock `gen_o`, which closes the loop by driving the detector's `gen` input.
- Contains a proportional-integral filter with saturation, a phase accumulator, a synchroniser and update-strobe pipeline, and an optional lock detector.

Parameters:
- ACC_W, 24, phase-accumulator and frequency-control-word width in bits
- FCW_INIT, 24'h010000, integrator value after reset or disable (gen = clk/256)
- FCW_MIN, 24'h008000, lower saturation bound for integrator and output word
- FCW_MAX, 24'h020000, upper saturation bound for integrator and output word
- KI, 16, integral step added or subtracted per update
- KP, 256, proportional offset applied for one update period
- LOCK_CNT, 32, consecutive alternating decisions required for lock (LOCK_DETECT_EN only)

Ports:
- clk_i  input  1  system clock
- reset_n_i  input  1  asynchronous, active-low reset
- enable_i  input  1  loop enable; low freezes the loop at FCW_INIT
- pd_i  input  1  phase-detector decision (1 = ref early, raise freq; 0 = gen early, lower freq); asynchronous to clk_i
- gen_o  output  1  generated clock, registered MSB of phase accumulator
- fcw_o  output  ACC_W  current effective frequency control word, registered
- update_o  output  1  one-cycle pulse when a decision is applied
- lock_o  output  1  lock indication (constant 0 without LOCK_DETECT_EN)

Behaviour:
- Reset (reset_n_i low, asynchronous):
  - acc = 0, gen_o = 0, integ = FCW_INIT, fcw_o = FCW_INIT, update_o = 0, lock_o = 0.
  - Sync flops, strobe pipeline and lock counter are cleared.
- Accumulator:
  - Every clk, acc <= acc + fcw_o, modulo 2^ACC_W (wrap is the intended output edge).
  - gen_o <= acc[ACC_W-1].
  - The accumulator runs regardless of enable_i.
- Synchroniser: pd_i passes through 2 flops to give pd_s.
- Update strobe:
  - gen_rise = gen_o & ~gen_q.
  - gen_rise is delayed 3 clk through a shift register; the output is update_o.
  - The 3-clk delay guarantees pd_s reflects the detector value captured at that gen edge.
  - If the next gen_rise arrives inside the pipeline, each strobe is still issued; none are dropped or merged.
- On update_o with enable_i = 1:
  - pd_s = 1: integ <= sat(integ + KI); fcw_o <= sat(integ + KI + KP).
  - pd_s = 0: integ <= sat(integ - KI); fcw_o <= sat(integ - KI - KP).
  - Arithmetic is done ACC_W+2 bits signed; sat() clamps to [FCW_MIN, FCW_MAX].
  - fcw_o holds its value until the next update. The proportional term persists for one gen period.
- enable_i = 0:
  - integ and fcw_o forced to FCW_INIT on the next clk.
  - update_o still pulses but is ignored; lock_o = 0 and the lock counter is cleared.
  - When enable_i rises, the first update acts from FCW_INIT.
- Reset mid-operation: all state returns to reset values immediately; in-flight strobes are discarded.
- Simultaneous enable_i fall and update_o: disable wins; fcw_o = FCW_INIT.

Optional Feature:
- Macro: BBPD_LOCK_DETECT_EN.
- Defined:
  - On each enabled update, compare pd_s with the previous applied decision.
  - If they differ, the counter increments, saturating at LOCK_CNT.
  - If they are equal, the counter clears and lock_o drops to 0 on the same update.
  - lock_o = 1 once the counter equals LOCK_CNT.
  - The first update after reset or enable only records the decision.
- Undefined: no counter logic; lock_o tied to 0.

Test Plan:
- Reset asserted mid-run with acc nonzero -> gen_o = 0, fcw_o = 24'h010000, update_o = 0 immediately (asynchronous, no clock edge needed).
- enable_i = 1, pd_i = 1 constant -> first update_o pulse 3 clk after gen_o rise; fcw_o = 24'h010110; after 4 updates fcw_o = 24'h010140.
- pd_i = 0 constant from reset -> integ steps down 16 per update, saturating at 24'h008000; fcw_o stays 24'h008000 and never underflows.
- pd_i = 1 constant with FCW_MAX = 24'h020000 -> fcw_o clamps at 24'h020000; gen_o period = 128 clk.
- Alternating pd_i per update (BBPD_LOCK_DETECT_EN defined) -> lock_o = 1 at the 33rd update; a single repeated decision -> lock_o = 0 on that update.
- enable_i dropped while fcw_o = 24'h010140 -> next clk fcw_o = 24'h010000, lock_o = 0; re-enable with pd_i = 0 -> fcw_o = 24'h00FEF0 on first update.
